// File: rtl/arb_requester.sv
// Client-side companion to a four-way round-robin arbiter: counts pending requests per
// client, presents them as req lines, serves each grant for BEATS cycles and advances ptr.
module arb_requester #(
    parameter int CNT_W = 3,
    parameter int BEATS = 4,
    parameter int FLUSH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] push,
    input  logic [3:0] grant,
    output logic [3:0] req,
    output logic [1:0] ptr,
    output logic       busy,
    output logic [1:0] active,
    output logic       done,
    output logic [3:0] overflow,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, WAIT, SERVE, GAP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       BEAT_END = 4'(BEATS - 1);
    localparam logic [2:0]       GAP_END  = 3'(FLUSH - 1);

    state_t           state;
    logic [CNT_W-1:0] pending [4];
    logic [3:0]       beat;
    logic [2:0]       gap;

    logic       last_beat;
    logic       any_pending;
    logic [1:0] grant_idx;
    logic       grant_legal;
    logic [3:0] dec;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        last_beat   = (state == SERVE) && (beat == BEAT_END);
        any_pending = 1'b0;
        grant_idx   = 2'd0;
        dec         = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (pending[i] != '0) any_pending = 1'b1;
            if (grant[i])         grant_idx   = 2'(i);
            if (last_beat && active == 2'(i)) dec[i] = 1'b1;
        end
        grant_legal = $onehot(grant) && (pending[grant_idx] != '0);
    end

    always_comb begin
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req[i] = (state == WAIT) && (pending[i] != '0);
        end
    end

    assign busy = (state == SERVE);
    assign done = last_beat;

    // Push and completion decrement in the same cycle cancel; a saturated push without a
    // decrement holds the count and raises the sticky overflow bit.
    // NOTE: the counter array is only four registers, so it is reset along with the rest of the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) pending[i] <= '0;
            overflow <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i] && !dec[i]) begin
                    if (pending[i] == CNT_MAX) overflow[i] <= 1'b1;
                    else                       pending[i]  <= pending[i] + 1'b1;
                end else if (dec[i] && !push[i]) begin
                    pending[i] <= pending[i] - 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            beat   <= 4'd0;
            gap    <= 3'd0;
            active <= 2'd0;
            ptr    <= 2'd0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_pending) state <= WAIT;
                WAIT: begin
                    if (grant != 4'b0000) begin
                        if (grant_legal) begin
                            active <= grant_idx;
                            beat   <= 4'd0;
                            state  <= SERVE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (last_beat) begin
                        ptr   <= active + 2'd1;
                        gap   <= 3'd0;
                        state <= GAP;
                    end else begin
                        beat <= beat + 4'd1;
                    end
                end
                GAP: begin
                    // Counters seen here already include the completion decrement.
                    if (gap == GAP_END) state <= any_pending ? WAIT : IDLE;
                    else                gap   <= gap + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester (CNT_W=3, BEATS=4, FLUSH=3): a per-cycle vector table
// for the basic service, then hand-written sequences for the multi-cycle corner cases.
module tb_arb_requester;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] push;
    logic [3:0] grant;
    logic [3:0] req;
    logic [1:0] ptr;
    logic       busy;
    logic [1:0] active;
    logic       done;
    logic [3:0] overflow;
    logic       err;

    int n_vec  = 0;
    int n_fail = 0;

    arb_requester #(.CNT_W(3), .BEATS(4), .FLUSH(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .grant    (grant),
        .req      (req),
        .ptr      (ptr),
        .busy     (busy),
        .active   (active),
        .done     (done),
        .overflow (overflow),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0] push;
        logic [3:0] grant;
        logic [3:0] req;
        logic       busy;
        logic       done;
        logic [1:0] ptr;
        logic       err;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench in cycle 0: the DUT is in IDLE and inputs driven now are sampled at edge 1.
    task automatic reset_dut();
        push  = 4'b0000;
        grant = 4'b0000;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        // Single request: push in cycle 0, grant in cycle 4.
        //            push     grant    req      busy  done  ptr    err
        tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};

        reset_dut();
        check("reset_outputs", {req, ptr, busy, active, done, overflow, err}, 16'h0000);

        for (int c = 0; c < 14; c++) begin
            push  = tbl[c].push;
            grant = tbl[c].grant;
            check($sformatf("single_c%0d", c), {7'd0, req, busy, done, ptr, err},
                  {7'd0, tbl[c].req, tbl[c].busy, tbl[c].done, tbl[c].ptr, tbl[c].err});
            tick();
        end

        // Pointer wrap and back-to-back service: clients 3 then 0.
        reset_dut();
        push = 4'b1001; tick();                 // c1
        push = 4'b0000; tick();                 // c2
        check("wrap_req_both", {12'd0, req}, {12'd0, 4'b1001});
        grant = 4'b1000; tick();                // c3
        grant = 4'b0000;
        check("wrap_serve3", {13'd0, busy, active}, {13'd0, 1'b1, 2'd3});
        tick(3);                                // c6
        check("wrap_done3", {15'd0, done}, {15'd0, 1'b1});
        tick();                                 // c7
        check("wrap_gap", {9'd0, req, busy, ptr}, {9'd0, 4'b0000, 1'b0, 2'd0});
        tick(3);                                // c10
        check("wrap_req0_after_gap", {12'd0, req}, {12'd0, 4'b0001});
        grant = 4'b0001; tick();                // c11
        grant = 4'b0000;
        check("wrap_serve0", {13'd0, busy, active}, {13'd0, 1'b1, 2'd0});
        tick(4);                                // c15
        check("wrap_ptr1", {14'd0, ptr}, {14'd0, 2'd1});
        tick(3);                                // c18
        check("wrap_idle", {11'd0, req, busy}, {11'd0, 4'b0000, 1'b0});

        // Saturation of client 2, then a push coincident with the completion decrement.
        reset_dut();
        push = 4'b0100;
        tick(8);                                // c8
        push = 4'b0000;
        check("sat_count", {13'd0, dut.pending[2]}, {13'd0, 3'd7});
        check("sat_ovf_req", {8'd0, overflow, req}, {8'd0, 4'b0100, 4'b0100});
        grant = 4'b0100; tick();                // c9
        grant = 4'b0000;
        tick(3);                                // c12
        check("sat_done", {15'd0, done}, {15'd0, 1'b1});
        push = 4'b0100; tick();                 // c13
        push = 4'b0000;
        check("sat_coincident", {7'd0, dut.pending[2], overflow, ptr},
              {7'd0, 3'd7, 4'b0100, 2'd3});

        // Illegal grants in WAIT, then a legal one.
        reset_dut();
        push = 4'b0010; tick();                 // c1
        push = 4'b0000; tick();                 // c2
        check("illegal_pre_err", {15'd0, err}, {15'd0, 1'b0});
        grant = 4'b0110; tick();                // c3
        check("illegal_multihot", {10'd0, err, busy, req}, {10'd0, 1'b1, 1'b0, 4'b0010});
        grant = 4'b1000; tick();                // c4
        check("illegal_zero_cnt", {10'd0, err, busy, req}, {10'd0, 1'b1, 1'b0, 4'b0010});
        grant = 4'b0000; tick();                // c5
        grant = 4'b0010; tick();                // c6
        grant = 4'b0000;
        check("illegal_then_legal", {12'd0, busy, err, active}, {12'd0, 1'b1, 1'b1, 2'd1});
        tick(3);                                // c9
        check("illegal_done", {15'd0, done}, {15'd0, 1'b1});
        tick();                                 // c10
        check("illegal_ptr", {14'd0, ptr}, {14'd0, 2'd2});

        // Stale grant held through SERVE and GAP.
        reset_dut();
        push = 4'b0001; tick();                 // c1
        push = 4'b0000; tick();                 // c2
        grant = 4'b0001;
        tick(6);                                // c8, mid GAP
        check("stale_gap", {11'd0, req, busy}, {11'd0, 4'b0000, 1'b0});
        tick(2);                                // c10
        grant = 4'b0000;
        check("stale_after", {10'd0, req, busy, err, ptr}, {10'd0, 4'b0000, 1'b0, 1'b0, 2'd1});
        tick();                                 // c11
        check("stale_no_extra", {12'd0, busy, dut.pending[0]}, {12'd0, 1'b0, 3'd0});

        // Reset in cycle 6 of the single-request scenario.
        reset_dut();
        push = 4'b0001; tick();                 // c1
        push = 4'b0000; tick(3);                // c4
        grant = 4'b0001; tick();                // c5
        grant = 4'b0000; tick();                // c6
        check("mid_serve_busy", {15'd0, busy}, {15'd0, 1'b1});
        #2 reset = 1'b1;
        #1;
        check("async_reset", {9'd0, busy, ptr, req, dut.pending[0]},
              {9'd0, 1'b0, 2'd0, 4'b0000, 3'd0});
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("no_done_%0d", i), {15'd0, done}, {15'd0, 1'b0});
        end
        reset = 1'b0;                           // c0
        push = 4'b0100; tick();                 // c1
        push = 4'b0000; tick();                 // c2
        check("post_reset_req", {12'd0, req}, {12'd0, 4'b0100});
        grant = 4'b0100; tick();                // c3
        grant = 4'b0000;
        check("post_reset_serve", {13'd0, busy, active}, {13'd0, 1'b1, 2'd2});
        tick(4);                                // c7
        check("post_reset_ptr", {13'd0, busy, ptr}, {13'd0, 1'b0, 2'd3});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
